// File: rtl/game_pkg.sv
// Shared definitions for the typing game: state encodings, button indices and mode limits.
package game_pkg;

    typedef enum logic [1:0] {
        SELECT    = 2'd0,
        COUNTDOWN = 2'd1,
        INGAME    = 2'd2,
        FINISH    = 2'd3
    } game_state_t;

    localparam int NUM_BTN   = 5;
    localparam int BTN_START = 4;
    localparam int BTN_BACK  = 3;
    localparam int BTN_MODE  = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    // Upper bounds keep value*100 within the downstream 15-bit counter.
    localparam int TIME_MIN  = 15;
    localparam int TIME_MAX  = 120;
    localparam int TIME_STEP = 15;
    localparam int TIME_DEF  = 30;
    localparam int WORD_MIN  = 5;
    localparam int WORD_MAX  = 95;
    localparam int WORD_STEP = 5;
    localparam int WORD_DEF  = 25;

endpackage

// File: rtl/game_controller_btn_edge.sv
// Rising-edge detector for a vector of debounced button levels; registers reset high
// so a button held through reset never produces a press.
module btn_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] lvl_p0;
    logic [WIDTH-1:0] lvl_p1;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            lvl_p0 <= '1;
            lvl_p1 <= '1;
        end else begin
            lvl_p0 <= level;
            lvl_p1 <= lvl_p0;
        end
    end

    assign press = lvl_p0 & ~lvl_p1;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: mode/value selection, start countdown, in-game supervision and
// result/best-score capture at game end.
module game_controller
    import game_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100,
    parameter int COUNT_DIGITS    = 3,
    parameter int TIME_MIN        = game_pkg::TIME_MIN,
    parameter int TIME_MAX        = game_pkg::TIME_MAX,
    parameter int TIME_STEP       = game_pkg::TIME_STEP,
    parameter int TIME_DEF        = game_pkg::TIME_DEF,
    parameter int WORD_MIN        = game_pkg::WORD_MIN,
    parameter int WORD_MAX        = game_pkg::WORD_MAX,
    parameter int WORD_STEP       = game_pkg::WORD_STEP,
    parameter int WORD_DEF        = game_pkg::WORD_DEF
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_back,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       finish,
    input  logic [9:0] wpm,
    input  logic [9:0] acc,
    output logic [1:0] state,
    output logic       mode,
    output logic [6:0] value,
    output logic [1:0] countdown,
    output logic [9:0] result_wpm,
    output logic [9:0] result_acc,
    output logic [9:0] best_wpm,
    output logic       new_best
);

    localparam int CNT_LOAD = TICKS_PER_DIGIT * COUNT_DIGITS - 1;
    localparam int CNT_W    = $clog2(CNT_LOAD + 1);

    function automatic logic [6:0] sat_up(input logic [6:0] v, input int step, input int lim);
        int s;
        s = int'(v) + step;
        return (s > lim) ? 7'(lim) : 7'(s);
    endfunction

    function automatic logic [6:0] sat_down(input logic [6:0] v, input int step, input int lim);
        int s;
        s = int'(v) - step;
        return (s < lim) ? 7'(lim) : 7'(s);
    endfunction

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [6:0]         value_q, value_d;
    logic               latch;
    logic [NUM_BTN-1:0] press;

    btn_edge #(.WIDTH(NUM_BTN)) u_btn_edge (
        .clk_div (clk_div),
        .rst     (rst),
        .level   ({btn_start, btn_back, btn_mode, btn_up, btn_down}),
        .press   (press)
    );

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q <= SELECT;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            value_q <= 7'(TIME_DEF);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        value_d = value_q;
        latch   = 1'b0;
        case (state_q)
            SELECT: begin
                if (press[BTN_START]) begin
                    state_d = COUNTDOWN;
                    cnt_d   = CNT_W'(CNT_LOAD);
                end else if (press[BTN_MODE]) begin
                    mode_d  = ~mode_q;
                    value_d = mode_q ? 7'(TIME_DEF) : 7'(WORD_DEF);
                end else if (press[BTN_UP] && !press[BTN_DOWN]) begin
                    value_d = mode_q ? sat_up(value_q, WORD_STEP, WORD_MAX)
                                     : sat_up(value_q, TIME_STEP, TIME_MAX);
                end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                    value_d = mode_q ? sat_down(value_q, WORD_STEP, WORD_MIN)
                                     : sat_down(value_q, TIME_STEP, TIME_MIN);
                end
            end
            COUNTDOWN: begin
                if (press[BTN_BACK]) begin
                    state_d = SELECT;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = INGAME;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INGAME: begin
                // Back outranks finish so an aborted game never records a score.
                if (press[BTN_BACK]) begin
                    state_d = SELECT;
                end else if (finish) begin
                    state_d = FINISH;
                    latch   = 1'b1;
                end
            end
            FINISH: begin
                if (press[BTN_START] || press[BTN_BACK]) state_d = SELECT;
            end
            default: state_d = SELECT;
        endcase
    end

    // wpm/acc are sampled on the transition edge, before the counter sees state leave INGAME.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            result_wpm <= '0;
            result_acc <= '0;
            best_wpm   <= '0;
            new_best   <= 1'b0;
        end else if (latch) begin
            result_wpm <= wpm;
            result_acc <= acc;
            if (wpm > best_wpm) begin
                best_wpm <= wpm;
                new_best <= 1'b1;
            end else begin
                new_best <= 1'b0;
            end
        end
    end

    assign state     = state_q;
    assign mode      = mode_q;
    assign value     = value_q;
    assign countdown = (state_q == COUNTDOWN)
                     ? 2'(cnt_q / CNT_W'(TICKS_PER_DIGIT) + CNT_W'(1)) : 2'd0;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: a behavioural model predicts every tick's
// outputs into a queue that a negedge monitor drains and compares.
module tb_game_controller;

    typedef struct packed {
        logic [1:0] state;
        logic       mode;
        logic [6:0] value;
        logic [1:0] countdown;
        logic [9:0] result_wpm;
        logic [9:0] result_acc;
        logic [9:0] best_wpm;
        logic       new_best;
    } snap_t;

    logic       clk_div = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btns = '0;   // {start, back, mode, up, down}
    logic       finish = 1'b0;
    logic [9:0] wpm = '0;
    logic [9:0] acc = '0;
    logic [1:0] state;
    logic       mode;
    logic [6:0] value;
    logic [1:0] countdown;
    logic [9:0] result_wpm, result_acc, best_wpm;
    logic       new_best;

    game_controller dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .btn_start  (btns[4]),
        .btn_back   (btns[3]),
        .btn_mode   (btns[2]),
        .btn_up     (btns[1]),
        .btn_down   (btns[0]),
        .finish     (finish),
        .wpm        (wpm),
        .acc        (acc),
        .state      (state),
        .mode       (mode),
        .value      (value),
        .countdown  (countdown),
        .result_wpm (result_wpm),
        .result_acc (result_acc),
        .best_wpm   (best_wpm),
        .new_best   (new_best)
    );

    initial forever #5 clk_div = ~clk_div;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: game phase, ticks spent counting down, and a level history.
    int         m_state, m_mode, m_value, m_elapsed;
    int         m_rw, m_ra, m_best, m_nb;
    logic [4:0] hist_1, hist_2;   // button levels seen one and two ticks ago

    task automatic model_edge();
        logic [4:0] pr;
        if (rst) begin
            m_state = 0; m_mode = 0; m_value = 30; m_elapsed = 0;
            m_rw = 0; m_ra = 0; m_best = 0; m_nb = 0;
            hist_1 = '1; hist_2 = '1;
            return;
        end
        pr = hist_1 & ~hist_2;
        hist_2 = hist_1;
        hist_1 = btns;
        case (m_state)
            0: begin
                if (pr[4]) begin
                    m_state = 1; m_elapsed = 0;
                end else if (pr[2]) begin
                    m_mode  = 1 - m_mode;
                    m_value = (m_mode == 1) ? 25 : 30;
                end else if (pr[1] != pr[0]) begin
                    int step, lo, hi;
                    step = (m_mode == 1) ? 5 : 15;
                    lo   = (m_mode == 1) ? 5 : 15;
                    hi   = (m_mode == 1) ? 95 : 120;
                    m_value = pr[1] ? m_value + step : m_value - step;
                    if (m_value > hi) m_value = hi;
                    if (m_value < lo) m_value = lo;
                end
            end
            1: begin
                if (pr[3]) m_state = 0;
                else if (m_elapsed == 299) m_state = 2;
                else m_elapsed++;
            end
            2: begin
                if (pr[3]) m_state = 0;
                else if (finish) begin
                    m_state = 3;
                    m_rw = int'(wpm);
                    m_ra = int'(acc);
                    if (int'(wpm) > m_best) begin
                        m_best = int'(wpm); m_nb = 1;
                    end else begin
                        m_nb = 0;
                    end
                end
            end
            default: if (pr[4] || pr[3]) m_state = 0;
        endcase
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.state      = 2'(m_state);
        s.mode       = 1'(m_mode);
        s.value      = 7'(m_value);
        s.countdown  = (m_state == 1) ? 2'(3 - m_elapsed / 100) : 2'd0;
        s.result_wpm = 10'(m_rw);
        s.result_acc = 10'(m_ra);
        s.best_wpm   = 10'(m_best);
        s.new_best   = 1'(m_nb);
        return s;
    endfunction

    // One tick: predict at the rising edge, then hand control back after the monitor's edge.
    task automatic step();
        @(posedge clk_div);
        model_edge();
        exp_q.push_back(model_snap());
        @(negedge clk_div);
        #1;
    endtask

    task automatic press(input int b);
        btns[b] = 1'b1;
        step();
        btns[b] = 1'b0;
        step();
    endtask

    always @(negedge clk_div) begin
        if (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front();
            a = '{state, mode, value, countdown, result_wpm, result_acc, best_wpm, new_best};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL snapshot t=%0t actual st=%0d md=%0d val=%0d cd=%0d rw=%0d ra=%0d best=%0d nb=%0d required st=%0d md=%0d val=%0d cd=%0d rw=%0d ra=%0d best=%0d nb=%0d",
                         $time, a.state, a.mode, a.value, a.countdown, a.result_wpm, a.result_acc,
                         a.best_wpm, a.new_best, e.state, e.mode, e.value, e.countdown,
                         e.result_wpm, e.result_acc, e.best_wpm, e.new_best);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, actual timeout required completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Value stepping and saturation in timed mode.
        repeat (10) press(1);
        repeat (10) press(0);

        // Word mode default, then simultaneous up/down.
        press(2);
        btns[1] = 1'b1; btns[0] = 1'b1;
        step();
        btns = '0;
        step();

        // Full countdown into a game that sets a best score.
        press(4);
        repeat (302) step();
        wpm = 10'd72; acc = 10'd95;
        step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        repeat (2) step();
        press(4);

        // Tie on the second game is not a new best.
        press(4);
        repeat (305) step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        repeat (2) step();
        press(3);

        // Abort during countdown, then mid-game, then back together with finish.
        press(4);
        repeat (148) step();
        press(3);
        press(4);
        repeat (320) step();
        press(3);
        press(4);
        repeat (310) step();
        wpm = 10'd500; acc = 10'd10;
        btns[3] = 1'b1;
        step();
        finish = 1'b1;
        step();
        btns[3] = 1'b0; finish = 1'b0;
        repeat (3) step();

        // Start held across reset release never fires.
        btns[4] = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        btns[4] = 1'b0;
        step();

        // Reach FINISH with a result, then reset there.
        press(4);
        repeat (302) step();
        wpm = 10'd88; acc = 10'd77; finish = 1'b1;
        step();
        finish = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Randomised play steered by the model's view of the game phase.
        repeat (12000) begin
            logic [4:0] b;
            b = '0;
            case (m_state)
                0: begin
                    b[1] = ($urandom_range(0, 2) == 0);
                    b[0] = ($urandom_range(0, 2) == 0);
                    b[2] = ($urandom_range(0, 9) == 0);
                    b[4] = ($urandom_range(0, 19) == 0);
                end
                1: b[3] = ($urandom_range(0, 399) == 0);
                2: b[3] = ($urandom_range(0, 79) == 0);
                default: begin
                    b[4] = ($urandom_range(0, 7) == 0);
                    b[3] = ($urandom_range(0, 7) == 0);
                end
            endcase
            btns   = b;
            wpm    = 10'($urandom_range(0, 1023));
            acc    = 10'($urandom_range(0, 100));
            finish = (m_state == 2) && ($urandom_range(0, 24) == 0);
            rst    = ($urandom_range(0, 2999) == 0);
            step();
        end
        rst = 1'b0; btns = '0; finish = 1'b0;
        repeat (3) step();

        repeat (4) if (exp_q.size() > 0) @(negedge clk_div);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for the typing game. It runs on the 100 Hz `clk_div` tick and owns the game `state`, the selected `mode` and `value` that drive the statistics counter, and the start countdown. It consumes that counter's `finish` level, and captures its `wpm`/`acc` at game end for the results screen and a best-score register.

## Interface
Parameters:
- `TICKS_PER_DIGIT`, 100: clk_div ticks per countdown digit (1 s).
- `COUNT_DIGITS`, 3: countdown starts at this digit.
- `TIME_MIN`/`TIME_MAX`/`TIME_STEP`/`TIME_DEF`, 15/120/15/30: mode 0 value (seconds).
- `WORD_MIN`/`WORD_MAX`/`WORD_STEP`/`WORD_DEF`, 5/95/5/25: mode 1 value (words).

Ports:
- `clk_div` in 1: 100 Hz game tick. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start`, `btn_back`, `btn_mode`, `btn_up`, `btn_down` in 1 each: debounced button levels, each held ≥1 tick.
- `finish` in 1: game-over level from the statistics counter, meaningful in INGAME.
- `wpm` in 10, `acc` in 10: live statistics, registered in the clk domain.
- `state` out 2: SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- `mode` out 1: 0 = timed game, 1 = word-count game.
- `value` out 7: seconds (mode 0) or word target (mode 1).
- `countdown` out 2: digit 3/2/1 shown during COUNTDOWN, otherwise 0.
- `result_wpm` out 10, `result_acc` out 10: values latched at game end.
- `best_wpm` out 10: highest `result_wpm` since reset.
- `new_best` out 1: last game set a new best.

## Operation
- **Buttons:** each is sampled into a previous-value register that resets to 1. A press is `cur & ~prev`, a one-tick pulse. A button held through reset does not fire.
- **SELECT:** press priority is start > mode > up/down.
  - `btn_mode` toggles `mode` and loads that mode's default `value`.
  - `btn_up` adds one step to `value`, saturating at MAX. `btn_down` subtracts one step, saturating at MIN.
  - up and down in the same tick: no change.
  - `btn_start` loads the countdown counter with `TICKS_PER_DIGIT*COUNT_DIGITS-1` (299) and moves to COUNTDOWN.
- **COUNTDOWN:**
  - The counter decrements by 1 each tick.
  - `countdown = cnt/TICKS_PER_DIGIT + 1`: 299..200 gives 3, 199..100 gives 2, 99..0 gives 1.
  - At cnt==0 the next state is INGAME.
  - `btn_back` returns to SELECT, clears the counter and latches nothing.
  - `mode` and `value` are frozen outside SELECT.
- **INGAME:**
  - `finish==1` moves to FINISH. On that same edge:
    - `result_wpm <= wpm`, `result_acc <= acc`.
    - If `wpm > best_wpm`: `best_wpm <= wpm` and `new_best <= 1`. Otherwise `new_best <= 0`.
  - `btn_back` takes priority over `finish`: it returns to SELECT with no latch.
- **FINISH:** results are held. `btn_start` or `btn_back` returns to SELECT, keeping `mode`, `value`, the results and `best_wpm`.
- **Arithmetic:** `value` ranges are bounded so that `value*100` ≤ 12000 fits the downstream 15-bit counter. `best_wpm` compares unsigned 10-bit values, and a tie is not a new best.

## Timing
- **Reset values:** `state`=SELECT, `mode`=0, `value`=TIME_DEF (30), `countdown`=0, `result_wpm`=0, `result_acc`=0, `best_wpm`=0, `new_best`=0. All button prev registers are 1.
- **Press latency:** a button level rising before edge N produces a press at edge N+1. The state or value change is visible after edge N+1.
- **COUNTDOWN length:** exactly 300 ticks, from the edge entering COUNTDOWN to the edge entering INGAME.
- **finish latency:** `finish` is sampled on each tick. The results latch and the FINISH transition happen on the same edge.
- **Domain crossing:** the downstream counter clears `wpm`/`acc` when `state`≠INGAME. Latching therefore uses values sampled before the `state` change is seen in the clk domain. `wpm`/`acc` are quasi-static relative to the 100 Hz tick, so no synchroniser is required.
- **Reset mid-game:** reset returns immediately to SELECT with all reset values, including `best_wpm`.

## Structure
- **Shared package `game_pkg`:** the state encodings SELECT/COUNTDOWN/INGAME/FINISH (reused by the statistics counter and the display) and the mode value limits and defaults.
- **Sub-module `btn_edge`:** a parameterised-width rising-edge detector with prev registers that reset to 1, instantiated once for the 5-bit button vector.

## Test plan
1. Reset, then `btn_up` ×10 in mode 0 → `value` 45, 60, … saturating at 120. Then `btn_down` ×10 → saturates at 15.
2. `btn_mode` → `mode`=1, `value`=25. Press up and down in the same tick → `value` stays 25.
3. `btn_start` → `countdown` reads 3 for 100 ticks, 2 for 100 ticks, 1 for 100 ticks, then `state`=INGAME with `countdown`=0.
4. In INGAME, drive `wpm`=72 and `acc`=95, then raise `finish` → FINISH with `result_wpm`=72, `result_acc`=95, `best_wpm`=72, `new_best`=1. A second game with `wpm`=72 → `new_best`=0.
5. Press `btn_back` at countdown tick 150, then `btn_back` mid-INGAME → each returns to SELECT with results unchanged. `finish` and `btn_back` in the same tick → SELECT.
6. Hold `btn_start` across reset release → no transition. Assert reset in FINISH → all outputs return to reset values.
